pfd_tdc_lock: RTL and testbench
===============================

// Module: pfd_tdc_lock
// PURPOSE
//  Sampled phase-frequency detector for the digital PLL loop. Synchronises ref_in and fb_in into the clk domain,
//  runs a tri-state PFD FSM that drives up/dn with a programmable anti-dead-zone overlap, and measures the signed
//  ref-to-fb lag in clk cycles (TDC). A lock detector asserts locked after a run of small errors.
//  Sits between the reference/divider outputs and the loop filter / charge-pump model.
// PARAMETERS
//  ERR_W        8   width of signed phase_err, 2..16; magnitude saturates at 2^(ERR_W-1)-1
//  SYNC_STAGES  2   synchroniser flops per input, >=2
//  DZ_CYC       1   cycles both up and dn stay high in CLEAR (anti-dead-zone), 0..15; 0 = CLEAR skipped
//  LOCK_TOL     2   max |phase_err| counted as in-lock
//  LOCK_CNT     16  consecutive in-tolerance measurements required to assert locked, >=1
// PORTS
//  clk        in   1      sampling clock, rising edge
//  ff_rst     in   1      reset, asynchronous, active-high
//  en         in   1      synchronous enable; 0 forces the FSM to IDLE
//  ref_in     in   1      reference clock, asynchronous to clk
//  fb_in      in   1      divided feedback clock, asynchronous to clk
//  up         out  1      pump-up request (registered)
//  dn         out  1      pump-down request (registered)
//  phase_err  out  ERR_W  signed lag, +ve = ref leads fb; held between updates
//  err_valid  out  1      one-cycle pulse when phase_err updates
//  locked     out  1      lock indicator
//  slip       out  1      cycle-slip pulse (see CONFIGURATION)
// BEHAVIOUR
//  - ff_rst=1 (any time, mid-operation included): all sync flops, pending flags, cnt and lock_cnt =0; state=IDLE;
//    up=dn=err_valid=locked=slip=0; phase_err=0.
//  - Edge detect: ref_e/fb_e = last sync stage & ~previous; first pulse SYNC_STAGES+1 clk after the input rises.
//  - Edges arriving in CLEAR set ref_pend/fb_pend; IDLE consumes ref_e|ref_pend and fb_e|fb_pend, then clears them.
//  - FSM states: IDLE, UP, DN, CLEAR. Outputs: up=1 in UP and CLEAR; dn=1 in DN and CLEAR.
//    IDLE: ref&fb same cycle -> CLEAR, phase_err=0, err_valid; ref only -> UP, cnt=1; fb only -> DN, cnt=1.
//    UP: no fb_e -> cnt=min(cnt+1, MAX). fb_e -> CLEAR, phase_err=+cnt, err_valid=1 next cycle.
//      A ref_e coinciding with that fb_e sets ref_pend.
//    DN: mirror of UP; fb_e increments cnt; ref_e -> CLEAR, phase_err=-cnt.
//    CLEAR: lasts DZ_CYC cycles, then IDLE. With DZ_CYC=0, UP/DN go directly to IDLE and up/dn never overlap.
//  - MAX = 2^(ERR_W-1)-1. Range is symmetric: phase_err never equals -2^(ERR_W-1).
//  - Latency: err_valid and phase_err are registered, asserted on the clk edge the FSM leaves UP/DN.
//  - Lock: on each err_valid, |phase_err|<=LOCK_TOL and not saturated -> lock_cnt=min(lock_cnt+1, LOCK_CNT);
//    otherwise lock_cnt=0 and locked=0. locked=1 on the cycle after lock_cnt reaches LOCK_CNT.
//  - en=0: state=IDLE, up=dn=0, cnt=lock_cnt=0, locked=0, pending flags cleared; phase_err holds its value.
//    Edge detect keeps running, so an input already high does not produce a false edge when en returns to 1.
// CONFIGURATION
//  PFD_SLIP_DETECT_EN defined: in UP a further ref_e with no fb_e (or in DN a further fb_e with no ref_e)
//    -> slip=1 for one cycle, cnt=MAX, lock_cnt=0, locked=0; the FSM stays in UP/DN.
//  Not defined: that extra same-side edge is ignored (cnt keeps counting). slip is tied to 0. The port is always present.
// TESTING
//  1 ff_rst pulsed mid-UP with en=1 -> up=dn=0 and locked=0 immediately; phase_err=0.
//  2 ERR_W=8, DZ_CYC=1: ref rises, fb rises 5 clk later -> up for 5 cycles then up=dn=1 for 1 cycle;
//    phase_err=+5 with a one-cycle err_valid.
//  3 fb leads ref by 3 clk -> dn, then phase_err=-3. ref and fb rise on the same clk -> phase_err=0, no up/dn-only phase.
//  4 ref leads fb by 200 clk, ERR_W=8 -> phase_err=+127 (saturated); lock_cnt reset.
//  5 LOCK_CNT=16, LOCK_TOL=2: 16 periods with lag 1 -> locked=1 after the 16th err_valid.
//    One lag of 4 -> locked=0 on the next cycle.
//  6 PFD_SLIP_DETECT_EN: two ref edges before any fb edge -> slip pulse, phase_err=+127 at the following fb edge.
//    Without the macro -> slip stays 0.

Source files
------------

// File: rtl/pfd_tdc_lock.sv
// Sampled tri-state PFD with TDC lag measurement and lock detector for the digital PLL.
// Optional cycle-slip detection is built when PFD_SLIP_DETECT_EN is defined.
`timescale 1ns/1ps
module pfd_tdc_lock #(
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DZ_CYC      = 1,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic                    clk,
  input  logic                    ff_rst,
  input  logic                    en,
  input  logic                    ref_in,
  input  logic                    fb_in,
  output logic                    up,
  output logic                    dn,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    locked,
  output logic                    slip
);

  localparam int MAG_W = ERR_W - 1;
  localparam int LC_W  = $clog2(LOCK_CNT + 1);
  localparam logic [MAG_W-1:0] MAX_MAG  = {MAG_W{1'b1}};
  localparam logic [MAG_W-1:0] ONE_MAG  = MAG_W'(1);
  localparam logic [LC_W-1:0]  LOCK_LIM = LC_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DN    = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  // With no dead-zone overlap the measurement goes straight back to IDLE.
  localparam state_t ST_AFTER = (DZ_CYC == 0) ? ST_IDLE : ST_CLEAR;

  logic [SYNC_STAGES-1:0] ref_sync_r, fb_sync_r;
  logic                   ref_prev_r, fb_prev_r;
  logic                   ref_e_s, fb_e_s;
  state_t                 state_r, state_nxt_s;
  logic [MAG_W-1:0]       cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [3:0]             dz_cnt_r, dz_nxt_s;
  logic                   ref_pend_r, fb_pend_r, ref_pend_nxt_s, fb_pend_nxt_s;
  logic [ERR_W-1:0]       phase_err_r, err_nxt_s, err_mag_s;
  logic                   err_valid_r, err_vld_nxt_s;
  logic                   slip_r, slip_nxt_s;
  logic                   up_r, dn_r, up_nxt_s, dn_nxt_s;
  logic [LC_W-1:0]        lock_cnt_r;
  logic                   locked_r, in_tol_s;

  assign ref_e_s   = ref_sync_r[SYNC_STAGES-1] & ~ref_prev_r;
  assign fb_e_s    = fb_sync_r[SYNC_STAGES-1] & ~fb_prev_r;
  assign cnt_inc_s = (cnt_r == MAX_MAG) ? MAX_MAG : cnt_r + ONE_MAG;

  // Input synchronisers and edge-detect history; they keep running while en=0.
  always_ff @(posedge clk or posedge ff_rst) begin
    if (ff_rst) begin
      ref_sync_r <= {SYNC_STAGES{1'b0}};
      fb_sync_r  <= {SYNC_STAGES{1'b0}};
      ref_prev_r <= 1'b0;
      fb_prev_r  <= 1'b0;
    end else begin
      ref_sync_r <= {ref_sync_r[SYNC_STAGES-2:0], ref_in};
      fb_sync_r  <= {fb_sync_r[SYNC_STAGES-2:0], fb_in};
      ref_prev_r <= ref_sync_r[SYNC_STAGES-1];
      fb_prev_r  <= fb_sync_r[SYNC_STAGES-1];
    end
  end

  // PFD state register together with the TDC counter and measurement outputs.
  always_ff @(posedge clk or posedge ff_rst) begin
    if (ff_rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= MAG_W'(0);
      dz_cnt_r    <= 4'd0;
      ref_pend_r  <= 1'b0;
      fb_pend_r   <= 1'b0;
      phase_err_r <= ERR_W'(0);
      err_valid_r <= 1'b0;
      slip_r      <= 1'b0;
      up_r        <= 1'b0;
      dn_r        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      dz_cnt_r    <= dz_nxt_s;
      ref_pend_r  <= ref_pend_nxt_s;
      fb_pend_r   <= fb_pend_nxt_s;
      phase_err_r <= err_nxt_s;
      err_valid_r <= err_vld_nxt_s;
      slip_r      <= slip_nxt_s;
      up_r        <= up_nxt_s;
      dn_r        <= dn_nxt_s;
    end
  end

  // Next-state, counter and measurement logic.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    dz_nxt_s       = dz_cnt_r;
    ref_pend_nxt_s = ref_pend_r;
    fb_pend_nxt_s  = fb_pend_r;
    err_nxt_s      = phase_err_r;
    err_vld_nxt_s  = 1'b0;
    slip_nxt_s     = 1'b0;
    if (!en) begin
      state_nxt_s    = ST_IDLE;
      cnt_nxt_s      = MAG_W'(0);
      dz_nxt_s       = 4'd0;
      ref_pend_nxt_s = 1'b0;
      fb_pend_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          ref_pend_nxt_s = 1'b0;
          fb_pend_nxt_s  = 1'b0;
          if ((ref_e_s | ref_pend_r) && (fb_e_s | fb_pend_r)) begin
            state_nxt_s   = ST_AFTER;
            dz_nxt_s      = 4'd1;
            err_nxt_s     = ERR_W'(0);
            err_vld_nxt_s = 1'b1;
          end else if (ref_e_s | ref_pend_r) begin
            state_nxt_s = ST_UP;
            cnt_nxt_s   = ONE_MAG;
          end else if (fb_e_s | fb_pend_r) begin
            state_nxt_s = ST_DN;
            cnt_nxt_s   = ONE_MAG;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_UP: begin
          if (fb_e_s) begin
            state_nxt_s    = ST_AFTER;
            dz_nxt_s       = 4'd1;
            err_nxt_s      = {1'b0, cnt_r};
            err_vld_nxt_s  = 1'b1;
            ref_pend_nxt_s = ref_pend_r | ref_e_s;
`ifdef PFD_SLIP_DETECT_EN
          end else if (ref_e_s) begin
            slip_nxt_s = 1'b1;
            cnt_nxt_s  = MAX_MAG;
`endif
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_DN: begin
          if (ref_e_s) begin
            state_nxt_s   = ST_AFTER;
            dz_nxt_s      = 4'd1;
            err_nxt_s     = ERR_W'(0) - {1'b0, cnt_r};
            err_vld_nxt_s = 1'b1;
            fb_pend_nxt_s = fb_pend_r | fb_e_s;
`ifdef PFD_SLIP_DETECT_EN
          end else if (fb_e_s) begin
            slip_nxt_s = 1'b1;
            cnt_nxt_s  = MAX_MAG;
`endif
          end else begin
            cnt_nxt_s = cnt_inc_s;
          end
        end
        ST_CLEAR: begin
          ref_pend_nxt_s = ref_pend_r | ref_e_s;
          fb_pend_nxt_s  = fb_pend_r | fb_e_s;
          if (dz_cnt_r >= 4'(DZ_CYC)) begin
            state_nxt_s = ST_IDLE;
            dz_nxt_s    = 4'd0;
          end else begin
            dz_nxt_s = dz_cnt_r + 4'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Pump outputs are decoded from the next state so they register in step with it.
  always_comb begin
    up_nxt_s = (state_nxt_s == ST_UP) || (state_nxt_s == ST_CLEAR);
    dn_nxt_s = (state_nxt_s == ST_DN) || (state_nxt_s == ST_CLEAR);
  end

  // A saturated measurement never counts toward lock even if the tolerance is wide.
  always_comb begin
    if (phase_err_r[ERR_W-1]) begin
      err_mag_s = ERR_W'(0) - phase_err_r;
    end else begin
      err_mag_s = phase_err_r;
    end
    in_tol_s = (err_mag_s <= ERR_W'(LOCK_TOL)) && (err_mag_s != {1'b0, MAX_MAG});
  end

  // Lock detector: run of in-tolerance measurements.
  always_ff @(posedge clk or posedge ff_rst) begin
    if (ff_rst) begin
      lock_cnt_r <= LC_W'(0);
      locked_r   <= 1'b0;
    end else if (!en || slip_nxt_s || (err_valid_r && !in_tol_s)) begin
      lock_cnt_r <= LC_W'(0);
      locked_r   <= 1'b0;
    end else if (err_valid_r) begin
      lock_cnt_r <= (lock_cnt_r == LOCK_LIM) ? LOCK_LIM : lock_cnt_r + LC_W'(1);
      locked_r   <= (lock_cnt_r == LOCK_LIM);
    end else begin
      locked_r   <= (lock_cnt_r == LOCK_LIM);
    end
  end

  assign up        = up_r;
  assign dn        = dn_r;
  assign phase_err = $signed(phase_err_r);
  assign err_valid = err_valid_r;
  assign locked    = locked_r;
  assign slip      = slip_r;

endmodule

// File: tb/tb_pfd_tdc_lock.sv
// Directed bench for pfd_tdc_lock at default parameters (ERR_W=8, SYNC_STAGES=2, DZ_CYC=1).
`timescale 1ns/1ps
module tb_pfd_tdc_lock;

  logic       clk = 1'b0;
  logic       ff_rst;
  logic       en;
  logic       ref_in;
  logic       fb_in;
  logic       up, dn, err_valid, locked, slip;
  logic [7:0] perr;

  int n_cmp = 0;
  int n_err = 0;

  int   vld_at, up_only, dn_only, both_on, vld_cnt, slip_cnt, hi_cnt;
  logic lk0, lk1, lk2;

  pfd_tdc_lock dut (
    .clk       (clk),
    .ff_rst    (ff_rst),
    .en        (en),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .up        (up),
    .dn        (dn),
    .phase_err (perr),
    .err_valid (err_valid),
    .locked    (locked),
    .slip      (slip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leader rises at N0, lagger at N(lag); samples every falling edge for lag+8 cycles.
  task automatic run_pair(input bit ref_first, input int lag,
                          output int v_at, output int u_only, output int d_only,
                          output int both, output int v_cnt,
                          output logic l0, output logic l1, output logic l2);
    v_at = -1; u_only = 0; d_only = 0; both = 0; v_cnt = 0;
    l0 = 1'b0; l1 = 1'b0; l2 = 1'b0;
    @(negedge clk);
    if (ref_first) ref_in = 1'b1; else fb_in = 1'b1;
    if (lag == 0) begin ref_in = 1'b1; fb_in = 1'b1; end
    for (int i = 1; i <= lag + 8; i++) begin
      @(negedge clk);
      if (up && !dn) u_only++;
      if (dn && !up) d_only++;
      if (up && dn) both++;
      if (err_valid) begin
        v_cnt++;
        if (v_at < 0) v_at = i;
      end
      if (v_at >= 0 && i == v_at)     l0 = locked;
      if (v_at >= 0 && i == v_at + 1) l1 = locked;
      if (v_at >= 0 && i == v_at + 2) l2 = locked;
      if (i == lag) begin ref_in = 1'b1; fb_in = 1'b1; end
    end
    ref_in = 1'b0; fb_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    ff_rst = 1'b1; en = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
    #1;
    chk("rst_up", up, 1'b0);
    chk("rst_dn", dn, 1'b0);
    chk("rst_vld", err_valid, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_slip", slip, 1'b0);
    chk("rst_perr", perr, 8'h00);
    repeat (2) @(negedge clk);
    ff_rst = 1'b0;
    repeat (3) @(negedge clk);

    // ref leads fb by 5
    run_pair(1'b1, 5, vld_at, up_only, dn_only, both_on, vld_cnt, lk0, lk1, lk2);
    chk("lag5_vld_at", vld_at, 32'd8);
    chk("lag5_up_only", up_only, 32'd5);
    chk("lag5_dn_only", dn_only, 32'd0);
    chk("lag5_overlap", both_on, 32'd1);
    chk("lag5_vld_cnt", vld_cnt, 32'd1);
    chk("lag5_perr", perr, 8'h05);

    // fb leads ref by 3
    run_pair(1'b0, 3, vld_at, up_only, dn_only, both_on, vld_cnt, lk0, lk1, lk2);
    chk("fb3_vld_at", vld_at, 32'd6);
    chk("fb3_dn_only", dn_only, 32'd3);
    chk("fb3_up_only", up_only, 32'd0);
    chk("fb3_overlap", both_on, 32'd1);
    chk("fb3_perr", perr, 8'hFD);

    // simultaneous edges
    run_pair(1'b1, 0, vld_at, up_only, dn_only, both_on, vld_cnt, lk0, lk1, lk2);
    chk("lag0_vld_at", vld_at, 32'd3);
    chk("lag0_up_only", up_only, 32'd0);
    chk("lag0_dn_only", dn_only, 32'd0);
    chk("lag0_perr", perr, 8'h00);

    // saturation
    run_pair(1'b1, 200, vld_at, up_only, dn_only, both_on, vld_cnt, lk0, lk1, lk2);
    chk("lag200_vld_at", vld_at, 32'd203);
    chk("lag200_up_only", up_only, 32'd200);
    chk("lag200_perr", perr, 8'h7F);

    // lock acquisition with 16 lag-1 measurements
    for (int k = 1; k <= 16; k++) begin
      run_pair(1'b1, 1, vld_at, up_only, dn_only, both_on, vld_cnt, lk0, lk1, lk2);
      if (k == 15) chk("lock_after15", locked, 1'b0);
    end
    chk("lock16_perr", perr, 8'h01);
    chk("lock16_vld_at", vld_at, 32'd4);
    chk("lock16_next", lk1, 1'b0);
    chk("lock16_next2", lk2, 1'b1);
    chk("lock16_held", locked, 1'b1);

    // one out-of-tolerance lag drops lock on the next cycle
    run_pair(1'b1, 4, vld_at, up_only, dn_only, both_on, vld_cnt, lk0, lk1, lk2);
    chk("lag4_perr", perr, 8'h04);
    chk("lag4_lock_at_vld", lk0, 1'b1);
    chk("lag4_lock_next", lk1, 1'b0);

    // en=0 mid-UP forces IDLE, holds phase_err, no false edge on re-enable
    @(negedge clk); ref_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("en_up_before", up, 1'b1);
    en = 1'b0;
    @(negedge clk);
    chk("en_up_off", up, 1'b0);
    chk("en_perr_hold", perr, 8'h04);
    repeat (2) @(negedge clk);
    en = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (up || dn) hi_cnt++;
    end
    chk("en_no_false_edge", hi_cnt, 32'd0);
    ref_in = 1'b0;
    repeat (4) @(negedge clk);

    // re-acquire lock, then reset mid-UP
    for (int k = 1; k <= 16; k++) begin
      run_pair(1'b1, 1, vld_at, up_only, dn_only, both_on, vld_cnt, lk0, lk1, lk2);
    end
    chk("relock", locked, 1'b1);
    @(negedge clk); ref_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_up", up, 1'b1);
    ff_rst = 1'b1;
    #1;
    chk("mid_rst_up", up, 1'b0);
    chk("mid_rst_dn", dn, 1'b0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_perr", perr, 8'h00);
    ref_in = 1'b0;
    @(negedge clk);
    ff_rst = 1'b0;
    repeat (4) @(negedge clk);

    // two ref edges before the fb edge
    slip_cnt = 0; vld_at = -1;
    @(negedge clk); ref_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (slip) slip_cnt++;
      if (err_valid && vld_at < 0) vld_at = i;
      if (i == 3)  ref_in = 1'b0;
      if (i == 6)  ref_in = 1'b1;
      if (i == 12) fb_in = 1'b1;
    end
    ref_in = 1'b0; fb_in = 1'b0;
    chk("slip_vld_at", vld_at, 32'd15);
`ifdef PFD_SLIP_DETECT_EN
    chk("slip_cnt", slip_cnt, 32'd1);
    chk("slip_perr", perr, 8'h7F);
`else
    chk("slip_cnt", slip_cnt, 32'd0);
    chk("slip_perr", perr, 8'h0C);
`endif
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
